// File: rtl/float_multiplier_pipe.sv
// Pipelined floating-point multiplier with valid/ready handshakes.
// Operand classify, mantissa product and normalise/round are registered stages; results are packed into an output register.
module float_multiplier_pipe #(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int BIAS          = 127
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLOAT_SIZE-1:0] a,
    input  logic [FLOAT_SIZE-1:0] b,
    input  logic                  round_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLOAT_SIZE-1:0] out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact,
    output logic                  invalid
);
    localparam int MW = MANTISSA_SIZE + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXPONENT_SIZE + 2;
    localparam logic [EXPONENT_SIZE-1:0] EXP_ONES  = '1;
    localparam logic [MANTISSA_SIZE-1:0] FRAC_ZERO = '0;
    localparam logic [FLOAT_SIZE-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage 1: unpack and classify
    logic [EXPONENT_SIZE-1:0] ea, eb;
    logic [MANTISSA_SIZE-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic nan1_d, inf1_d, zero1_d;
    logic [EW-1:0] e1_d;

    assign ea = a[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    assign eb = b[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    assign fa = a[MANTISSA_SIZE-1:0];
    assign fb = b[MANTISSA_SIZE-1:0];

    always_comb begin
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_inf   = (ea == EXP_ONES) && (fa == '0);
        b_inf   = (eb == EXP_ONES) && (fb == '0);
        a_nan   = (ea == EXP_ONES) && (fa != '0);
        b_nan   = (eb == EXP_ONES) && (fb != '0);
        nan1_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        inf1_d  = (a_inf || b_inf) && !nan1_d;
        zero1_d = (a_zero || b_zero) && !nan1_d && !inf1_d;
        e1_d    = EW'(ea) + EW'(eb) - EW'(BIAS);
    end

    logic          v1_q, sign1_q, nan1_q, inf1_q, zero1_q, rm1_q;
    logic [EW-1:0] e1_q;
    logic [MW-1:0] ma1_q, mb1_q;

    // Stage 2: mantissa product
    logic          v2_q, sign2_q, nan2_q, inf2_q, zero2_q, rm2_q;
    logic [EW-1:0] e2_q;
    logic [PW-1:0] prod2_q;

    // Stage 3: normalise and round
    logic [MANTISSA_SIZE-1:0] mant_n, frac3_d;
    logic                     guard_n, sticky_n, inc_n, carry_n;
    logic [EW-1:0]            e_n, e3_d;

    always_comb begin
        mant_n   = prod2_q[PW-3 -: MANTISSA_SIZE];
        guard_n  = prod2_q[PW-3-MANTISSA_SIZE];
        sticky_n = |prod2_q[PW-4-MANTISSA_SIZE:0];
        e_n      = e2_q;
        if (prod2_q[PW-1]) begin
            mant_n   = prod2_q[PW-2 -: MANTISSA_SIZE];
            guard_n  = prod2_q[PW-2-MANTISSA_SIZE];
            sticky_n = |prod2_q[PW-3-MANTISSA_SIZE:0];
            e_n      = e2_q + EW'(1);
        end
        inc_n              = !rm2_q && guard_n && (sticky_n || mant_n[0]);
        {carry_n, frac3_d} = {1'b0, mant_n} + {{MANTISSA_SIZE{1'b0}}, inc_n};
        e3_d               = e_n + EW'(carry_n);
    end

    logic                     v3_q, sign3_q, nan3_q, inf3_q, zero3_q, inx3_q;
    logic [EW-1:0]            e3_q;
    logic [MANTISSA_SIZE-1:0] frac3_q;

    // Output: range checks after rounding, specials take precedence
    logic [FLOAT_SIZE-1:0] out_d;
    logic                  ovf_d, unf_d, inx_d, inv_d;

    always_comb begin
        out_d = {sign3_q, e3_q[EXPONENT_SIZE-1:0], frac3_q};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = inx3_q;
        inv_d = 1'b0;
        if (nan3_q) begin
            out_d = QNAN;
            inx_d = 1'b0;
            inv_d = 1'b1;
        end else if (inf3_q) begin
            out_d = {sign3_q, EXP_ONES, FRAC_ZERO};
            inx_d = 1'b0;
        end else if (zero3_q) begin
            out_d = {sign3_q, {EXPONENT_SIZE{1'b0}}, FRAC_ZERO};
            inx_d = 1'b0;
        end else if (!e3_q[EW-1] && (e3_q >= EW'(EXP_ONES))) begin
            out_d = {sign3_q, EXP_ONES, FRAC_ZERO};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (e3_q[EW-1] || (e3_q == '0)) begin
            out_d = {sign3_q, {EXPONENT_SIZE{1'b0}}, FRAC_ZERO};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    logic                  out_valid_q, ovf_q, unf_q, inx_q, inv_q;
    logic [FLOAT_SIZE-1:0] out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else if (!stall) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            out_valid_q <= v3_q;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
            inv_q       <= inv_d;
        end
    end

    // Datapath carries no reset; the valid bits qualify it
    always_ff @(posedge clk) begin
        if (!stall) begin
            sign1_q <= a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
            e1_q    <= e1_d;
            ma1_q   <= {1'b1, fa};
            mb1_q   <= {1'b1, fb};
            nan1_q  <= nan1_d;
            inf1_q  <= inf1_d;
            zero1_q <= zero1_d;
            rm1_q   <= round_mode;

            sign2_q <= sign1_q;
            e2_q    <= e1_q;
            prod2_q <= PW'(ma1_q) * PW'(mb1_q);
            nan2_q  <= nan1_q;
            inf2_q  <= inf1_q;
            zero2_q <= zero1_q;
            rm2_q   <= rm1_q;

            sign3_q <= sign2_q;
            e3_q    <= e3_d;
            frac3_q <= frac3_d;
            inx3_q  <= guard_n || sticky_n;
            nan3_q  <= nan2_q;
            inf3_q  <= inf2_q;
            zero3_q <= zero2_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;
    assign invalid   = inv_q;
endmodule

// File: tb/tb_float_multiplier_pipe.sv
// Scoreboard bench for float_multiplier_pipe: directed vectors, stall hold, reset flush.
module tb_float_multiplier_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, round_mode, out_valid, out_ready;
    logic [31:0] a, b, out;
    logic        overflow, underflow, inexact, invalid;

    float_multiplier_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .round_mode(round_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .overflow(overflow),
        .underflow(underflow), .inexact(inexact), .invalid(invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on every output transfer; checks hold and in_ready while stalled
    logic        held_v = 1'b0;
    logic [35:0] held;
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v)
                check("stall_hold", {28'd0, out, overflow, underflow, inexact, invalid}, {28'd0, held});
            if (out_valid && !out_ready) begin
                check("in_ready_stall", {63'd0, in_ready}, 64'd0);
                held_v = 1'b1;
                held   = {out, overflow, underflow, inexact, invalid};
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h with nothing outstanding", out);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", {32'd0, out}, {32'd0, mon_e.res});
                    check("flags", {60'd0, overflow, underflow, inexact, invalid}, {60'd0, mon_e.flg});
                    if (mon_e.chk_lat)
                        check("latency", 64'(cyc - mon_e.acc), 64'd3);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the acceptance edge
    task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic rm,
                         input logic [31:0] eres, input logic [3:0] eflg,
                         input bit lat, input bit push);
        int w;
        w          = 0;
        a          = xa;
        b          = xb;
        round_mode = rm;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1 for 100 cycles");
        end else if (push) begin
            sb.push_back('{eres, eflg, cyc + 1, lat});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // flags order: {overflow, underflow, inexact, invalid}
    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        round_mode = 1'b0;
        a          = '0;
        b          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out", {32'd0, out}, 64'd0);
        check("reset_flags", {60'd0, overflow, underflow, inexact, invalid}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back to back at full throughput
        issue(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 1, 1);
        issue(32'h3FC00001, 32'h3FC00001, 1'b0, 32'h40100002, 4'b0010, 1, 1);
        issue(32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100001, 4'b0010, 1, 1);
        issue(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b1010, 1, 1);
        issue(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000, 4'b1010, 1, 1);
        issue(32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0110, 1, 1);
        issue(32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 4'b0000, 1, 1);
        issue(32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b0001, 1, 1);
        issue(32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000, 1, 1);
        issue(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001, 1, 1);
        issue(32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000, 1, 1);
        issue(32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0010, 1, 1);
        issue(32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 4'b0010, 1, 1);
        drain();

        // Five ops with out_ready held low for 4 cycles from the first out_valid
        fork
            begin
                issue(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 0, 1);
                issue(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 0, 1);
                issue(32'h40400000, 32'h40400000, 1'b0, 32'h41100000, 4'b0000, 0, 1);
                issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 0, 1);
                issue(32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 4'b0000, 0, 1);
            end
            begin
                int w;
                w = 0;
                do begin
                    @(posedge clk);
                    #1;
                    w++;
                end while (!out_valid && w < 50);
                if (!out_valid) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stall_wait: got out_valid 0 expected 1");
                end
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight; neither may emerge
        issue(32'h3FC00000, 32'h40000000, 1'b0, 32'h0, 4'b0, 0, 0);
        issue(32'h40000000, 32'h40000000, 1'b0, 32'h0, 4'b0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_out", {32'd0, out}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_flush", {63'd0, in_ready}, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        issue(32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 4'b0000, 1, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/float_multiplier_pipe.md
Name: float_multiplier_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output.
- Successor to the combinational float multiplier; adds:
  - 3-stage pipeline with backpressure
  - selectable rounding (round-to-nearest-even or truncate)
  - special-value handling (zero, infinity, NaN, flush-to-zero)
  - an invalid-operation flag
- Sits between operand-issue logic and the FPU result/writeback path; one product per cycle at full throughput.

Parameters:
FLOAT_SIZE, 32, total float bit-length (= 1 + EXPONENT_SIZE + MANTISSA_SIZE)
EXPONENT_SIZE, 8, exponent field width
MANTISSA_SIZE, 23, stored fraction width (hidden bit implicit)
BIAS, 127, exponent bias

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands a/b/round_mode valid this cycle
in_ready  output  1  block accepts operands this cycle
a  input  FLOAT_SIZE  first operand
b  input  FLOAT_SIZE  second operand
round_mode  input  1  0 = round-to-nearest-even, 1 = truncate (toward zero)
out_valid  output  1  out and flags valid
out_ready  input  1  consumer accepts result this cycle
out  output  FLOAT_SIZE  product
overflow  output  1  finite result exceeded range; out = signed infinity
underflow  output  1  result below min normal; out = signed zero
inexact  output  1  rounded result differs from exact product
invalid  output  1  inf*0 or any NaN operand

Behaviour:
- Reset (synchronous, active-high, takes priority over all else):
  - All stage valid bits cleared; out_valid=0; out and all four flags driven 0.
  - in_ready=1 the cycle after reset deasserts.
  - Operations in flight when reset asserts are discarded and never emerge.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Global stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every pipeline register holds and out/flags stay stable.
  - Bubbles propagate normally; there is no bubble collapse.
- Latency: exactly 3 cycles. An operand accepted at edge N gives out_valid at edge N+3 if there was no stall.
- Throughput: 1 op/cycle. Results leave in acceptance order.
- Stage 1, unpack/classify:
  - Sign = sa ^ sb.
  - Exponent field 0 → operand treated as signed zero (denormals flushed; no inexact from flushing).
  - Exponent all-ones: fraction 0 = infinity, else NaN.
  - Exponent sum e = ea + eb - BIAS, in signed EXPONENT_SIZE+2 bits.
- Stage 2: (MANTISSA_SIZE+1)x(MANTISSA_SIZE+1) unsigned product of {1,ma}·{1,mb}, width 2*(MANTISSA_SIZE+1).
- Stage 3, normalise/round/pack:
  - If product MSB=1: shift right 1 and e += 1.
  - Guard bit = first bit below LSB; sticky = OR of all remaining lower bits.
  - RNE: increment when guard && (sticky || LSB).
  - Truncate: never increment.
  - Rounding carry out of the fraction → fraction 0, e += 1.
  - inexact = guard | sticky (regular path only).
- Range checks, applied after rounding:
  - e >= 2^EXPONENT_SIZE-1 → out = {sign, all-ones, 0}; overflow=1, inexact=1. Applies in both modes.
  - e <= 0 → out = {sign, 0, 0}; underflow=1, inexact=1.
- Specials, which override the regular path with all other flags 0:
  - NaN operand, or inf*0 → canonical NaN {0, all-ones, 1<<(MANTISSA_SIZE-1)}; invalid=1.
  - inf * finite-nonzero or inf*inf → signed infinity.
  - zero * finite → signed zero.

Test Plan:
- 0x3FC00000 * 0x40000000, RNE, out_ready=1 → 0x40400000 exactly 3 cycles after acceptance; all flags 0.
- 0x3FC00001 * 0x3FC00001 → RNE: 0x40100002 with inexact=1; truncate: 0x40100001 with inexact=1.
- 0x7F000000 * 0x7F000000 → 0x7F800000, overflow=1, inexact=1. 0x00800000 * 0x00800000 → 0x00000000, underflow=1, inexact=1. 0x80000000 * 0x3F800000 → 0x80000000, flags 0.
- 0x7F800000 * 0x00000000 → 0x7FC00000, invalid=1. 0xFF800000 * 0x40000000 → 0xFF800000, flags 0.
- Issue 5 back-to-back ops with out_ready low for 4 cycles from the first out_valid:
  - out stays stable while held.
  - in_ready=0 while stalled.
  - All 5 results emerge in order with none lost or duplicated.
- Assert reset with 2 ops in flight → out_valid=0 and out=0 next cycle; neither op ever appears; a new op issued after reset returns correctly at latency 3.
